// File: rtl/folded_peak_scanner.sv
// Folds BPO*OCT DFT bins into one circular octave profile, then scans it for
// thresholded local maxima and streams interpolated peak positions.
module folded_peak_scanner #(
  parameter int N        = 16,
  parameter int BPO      = 24,
  parameter int OCT      = 5,
  parameter int FPF      = 11,
  parameter int MAXPEAKS = 12,
  localparam int BINS    = BPO * OCT,
  localparam int AW      = $clog2(BINS),
  localparam int FW      = N + $clog2(OCT),
  localparam int BW      = $clog2(BPO),
  localparam int PW      = BW + FPF,
  localparam int CW      = $clog2(MAXPEAKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [FW-1:0] threshold,
  output logic [AW-1:0] binAddr,
  input  logic [N-1:0]  binData,
  output logic          busy,
  output logic          done,
  output logic          peakValid,
  input  logic          peakReady,
  output logic [PW-1:0] peakPos,
  output logic [FW-1:0] peakAmp,
  output logic [CW-1:0] peakCount,
  output logic          overflow
);

  localparam int DW = $clog2(FPF);
  localparam logic [BW-1:0] LAST_B     = BW'(BPO - 1);
  localparam logic [BW-1:0] ZERO_B     = {BW{1'b0}};
  localparam logic [BW-1:0] ONE_B      = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   FOLD_END   = (AW+1)'(BINS);
  localparam logic [AW:0]   ADDR_END   = (AW+1)'(BINS - 1);
  localparam logic [DW-1:0] DIV_END    = DW'(FPF - 1);
  localparam logic [PW:0]   HALF_POS   = (PW+1)'(2 ** (FPF - 1));
  localparam logic [PW:0]   WRAP_POS   = (PW+1)'(BPO * (2 ** FPF));
  localparam logic [CW-1:0] PEAK_LIMIT = CW'(MAXPEAKS);

  typedef enum logic [2:0] {S_IDLE, S_FOLD, S_SCAN, S_DIV, S_EMIT, S_DONE} state_t;

  state_t        state_r, state_s;
  logic [FW-1:0] folded_r [BPO];
  logic [FW-1:0] thr_r;
  logic [AW:0]   fcnt_r;
  logic [BW-1:0] mod_r, cap_idx_r, b_r;
  logic          cap_vld_r;
  logic [FW:0]   den_r, rem_r;
  logic [FPF-2:0] q_r;
  logic [DW-1:0] dcnt_r;

  logic [BW-1:0] bl_s, br_s;
  logic [FW-1:0] l_s, c_s, r_s, dl_s, dr_s;
  logic          peak_s, full_s, last_s;
  logic [FW+1:0] rem2_s;
  logic          ge_s;
  logic [FW:0]   rem_nx_s;
  logic [FPF-1:0] q_nx_s;
  logic [PW:0]   pos_raw_s, pos_s;

  // Neighbour lookup with circular wrap, peak test and one restoring-divide step
  always_comb begin
    bl_s      = (b_r == ZERO_B) ? LAST_B : b_r - ONE_B;
    br_s      = (b_r == LAST_B) ? ZERO_B : b_r + ONE_B;
    l_s       = folded_r[bl_s];
    c_s       = folded_r[b_r];
    r_s       = folded_r[br_s];
    dl_s      = c_s - l_s;
    dr_s      = c_s - r_s;
    peak_s    = (c_s > l_s) && (c_s > r_s) && (c_s > thr_r);
    full_s    = (peakCount >= PEAK_LIMIT);
    last_s    = (b_r == LAST_B);
    rem2_s    = {rem_r, 1'b0};
    ge_s      = (rem2_s >= {1'b0, den_r});
    rem_nx_s  = ge_s ? (FW+1)'(rem2_s - {1'b0, den_r}) : rem2_s[FW:0];
    q_nx_s    = {q_r, ge_s};
    // Centre offset of half a bin; a negative result wraps to the top of the octave
    pos_raw_s = {1'b0, b_r, {FPF{1'b0}}} + (PW+1)'(q_nx_s) - HALF_POS;
    pos_s     = pos_raw_s[PW] ? pos_raw_s + WRAP_POS : pos_raw_s;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: if (start) state_s = S_FOLD; else state_s = S_IDLE;
      S_FOLD: if (fcnt_r == FOLD_END) state_s = S_SCAN; else state_s = S_FOLD;
      S_SCAN: begin
        if (peak_s && !full_s) state_s = S_DIV;
        else if (last_s)       state_s = S_DONE;
        else                   state_s = S_SCAN;
      end
      S_DIV:  if (dcnt_r == DIV_END) state_s = S_EMIT; else state_s = S_DIV;
      S_EMIT: begin
        if (peakReady) state_s = last_s ? S_DONE : S_SCAN;
        else           state_s = S_EMIT;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath: fold accumulation, scan pointer, divider and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BPO; i++) folded_r[i] <= '0;
      thr_r <= '0; fcnt_r <= '0; mod_r <= '0; cap_idx_r <= '0; cap_vld_r <= 1'b0;
      b_r <= '0; den_r <= '0; rem_r <= '0; q_r <= '0; dcnt_r <= '0;
      binAddr <= '0; busy <= 1'b0; done <= 1'b0; peakValid <= 1'b0;
      peakPos <= '0; peakAmp <= '0; peakCount <= '0; overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < BPO; i++) folded_r[i] <= '0;
            thr_r <= threshold; peakCount <= '0; overflow <= 1'b0; busy <= 1'b1;
            binAddr <= '0; mod_r <= '0; fcnt_r <= '0; cap_vld_r <= 1'b0; b_r <= '0;
          end
        end
        S_FOLD: begin
          // Read data lags the address by one cycle, so accumulate the previous capture
          if (cap_vld_r) folded_r[cap_idx_r] <= folded_r[cap_idx_r] + FW'(binData);
          cap_vld_r <= (fcnt_r < FOLD_END);
          cap_idx_r <= mod_r;
          fcnt_r    <= fcnt_r + (AW+1)'(1);
          if (fcnt_r < ADDR_END) begin
            binAddr <= binAddr + AW'(1);
            mod_r   <= (mod_r == LAST_B) ? ZERO_B : mod_r + ONE_B;
          end
        end
        S_SCAN: begin
          if (peak_s && !full_s) begin
            den_r   <= {1'b0, dl_s} + {1'b0, dr_s};
            rem_r   <= {1'b0, dl_s};
            q_r     <= '0;
            dcnt_r  <= '0;
            peakAmp <= c_s;
          end else begin
            if (peak_s) overflow <= 1'b1;
            if (!last_s) b_r <= b_r + ONE_B;
          end
        end
        S_DIV: begin
          rem_r  <= rem_nx_s;
          q_r    <= q_nx_s[FPF-2:0];
          dcnt_r <= dcnt_r + DW'(1);
          if (dcnt_r == DIV_END) begin
            peakPos   <= PW'(pos_s);
            peakValid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (peakReady) begin
            peakValid <= 1'b0;
            peakCount <= peakCount + CW'(1);
            if (!last_s) b_r <= b_r + ONE_B;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_folded_peak_scanner.sv
// Randomised and directed bench for folded_peak_scanner against a plain-arithmetic
// model of the fold / local-maximum / interpolation rules.
module tb_folded_peak_scanner;
  localparam int N = 16, BPO = 24, OCT = 5, FPF = 11, MAXP = 4;
  localparam int BINS = BPO * OCT;
  localparam int FW = 19, PW = 16, CW = 3, AW = 7;

  logic clk = 1'b0;
  logic rst, start, peakReady;
  logic [FW-1:0] threshold;
  logic [AW-1:0] binAddr;
  logic [N-1:0]  binData;
  logic busy, done, peakValid, overflow;
  logic [PW-1:0] peakPos;
  logic [FW-1:0] peakAmp;
  logic [CW-1:0] peakCount;
  logic [N-1:0]  mem [BINS];

  folded_peak_scanner #(.N(N), .BPO(BPO), .OCT(OCT), .FPF(FPF), .MAXPEAKS(MAXP)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold), .binAddr(binAddr),
    .binData(binData), .busy(busy), .done(done), .peakValid(peakValid),
    .peakReady(peakReady), .peakPos(peakPos), .peakAmp(peakAmp),
    .peakCount(peakCount), .overflow(overflow));

  always #5 clk = ~clk;
  always @(posedge clk) binData <= mem[binAddr];

  int n_cmp = 0, n_fail = 0;
  int obs_pos[$], obs_amp[$], exp_pos[$], exp_amp[$];
  int exp_ovf, obs_count, obs_ovf, obs_busy, done_cyc, timed_out, unstable, early_idle;

  task automatic clear_mem();
    for (int i = 0; i < BINS; i++) mem[i] = '0;
  endtask

  // Reference: fold by modulo, scan circularly, interpolate with integer division
  task automatic model(input int thr);
    longint f[BPO];
    longint l, c, r, q;
    exp_pos.delete(); exp_amp.delete(); exp_ovf = 0;
    for (int b = 0; b < BPO; b++) f[b] = 0;
    for (int i = 0; i < BINS; i++) f[i % BPO] += longint'(mem[i]);
    for (int b = 0; b < BPO; b++) begin
      l = f[(b + BPO - 1) % BPO]; c = f[b]; r = f[(b + 1) % BPO];
      if (c > l && c > r && c > longint'(thr)) begin
        if (exp_pos.size() < MAXP) begin
          q = ((c - l) * (longint'(1) << FPF)) / ((c - l) + (c - r));
          exp_pos.push_back(int'((b * 2048 + q - 1024 + BPO * 2048) % (BPO * 2048)));
          exp_amp.push_back(int'(c));
        end else exp_ovf = 1;
      end
    end
  endtask

  // Drives one run and records what the DUT emitted; stall holds peakReady low per peak
  task automatic run_scan(input int thr, input int stall, input bit poke);
    int hold;
    int sp, sa, sc;
    hold = 0; sp = 0; sa = 0; sc = 0;
    obs_pos.delete(); obs_amp.delete();
    timed_out = 1; unstable = 0; early_idle = 0; done_cyc = -1;
    @(negedge clk); threshold = FW'(thr); start = 1'b1; peakReady = (stall == 0);
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (poke) begin
        start = (k == 20);
        if (k == 20) threshold = '0;
      end
      if (done) begin
        done_cyc = k; timed_out = 0;
        obs_count = int'(peakCount); obs_ovf = int'(overflow); obs_busy = int'(busy);
        break;
      end
      if (!busy) early_idle = 1;
      if (peakValid) begin
        if (hold < stall) begin
          if (hold == 0) begin sp = peakPos; sa = peakAmp; sc = peakCount; end
          else if (peakPos !== PW'(sp) || peakAmp !== FW'(sa) || peakCount !== CW'(sc)) unstable = 1;
          peakReady = 1'b0; hold++;
        end else begin
          if (stall > 0 && (peakPos !== PW'(sp) || peakAmp !== FW'(sa) || peakCount !== CW'(sc)))
            unstable = 1;
          peakReady = 1'b1; hold = 0;
          obs_pos.push_back(int'(peakPos)); obs_amp.push_back(int'(peakAmp));
        end
      end
    end
    start = 1'b0; peakReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; peakReady = 1'b0; threshold = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, peakValid, overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, peakValid, overflow});
    end
    n_cmp++;
    if (binAddr !== '0 || peakPos !== '0 || peakAmp !== '0 || peakCount !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr=%0d pos=%0d amp=%0d cnt=%0d want 0",
                         binAddr, peakPos, peakAmp, peakCount);
    end
    start = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_directed();
    int thr, en, ep, ea;
    for (int s = 0; s < 6; s++) begin
      clear_mem(); thr = 0; en = 1; ep = 0; ea = 0;
      case (s)
        0: begin mem[7] = 16'd2000; mem[6] = 16'd300; mem[8] = 16'd300; ep = 14336; ea = 2000; end
        1: begin mem[23] = 16'd100; mem[0] = 16'd500; mem[1] = 16'd300; ep = 341; ea = 500; end
        2: begin mem[23] = 16'd300; mem[0] = 16'd500; mem[1] = 16'd100; ep = 48810; ea = 500; end
        default: begin
          for (int o = 0; o < OCT; o++) mem[o * BPO + 5] = 16'd1000;
          ep = 10240; ea = 5000;
          if (s == 4) begin thr = 5000; en = 0; end
          if (s == 5) thr = 4999;
        end
      endcase
      run_scan(thr, 0, 1'b0);
      n_cmp++;
      if (timed_out !== 0 || obs_pos.size() !== en) begin
        n_fail++; $display("FAIL dir%0d_npeaks: got %0d (timeout=%0d) want %0d", s, obs_pos.size(), timed_out, en);
      end
      if (en == 1) begin
        n_cmp++;
        if (obs_pos.size() != 1 || obs_pos[0] !== ep || obs_amp[0] !== ea) begin
          n_fail++; $display("FAIL dir%0d_peak: got pos=%0d amp=%0d want pos=%0d amp=%0d", s,
                             (obs_pos.size() > 0) ? obs_pos[0] : -1, (obs_amp.size() > 0) ? obs_amp[0] : -1, ep, ea);
        end
      end
      n_cmp++;
      if (obs_count !== en || obs_busy !== 0 || obs_ovf !== 0 || early_idle !== 0) begin
        n_fail++; $display("FAIL dir%0d_status: got cnt=%0d busy=%0d ovf=%0d early_idle=%0d want %0d/0/0/0",
                           s, obs_count, obs_busy, obs_ovf, early_idle, en);
      end
      if (en == 0) begin
        n_cmp++;
        if (done_cyc !== BINS + BPO + 2) begin
          n_fail++; $display("FAIL dir%0d_done_latency: got %0d want %0d", s, done_cyc, BINS + BPO + 2);
        end
      end
    end
  endtask

  task automatic test_overflow();
    clear_mem();
    for (int b = 1; b < BPO; b += 2) mem[b] = 16'd1000;
    run_scan(0, 0, 1'b0);
    n_cmp++;
    if (timed_out !== 0 || obs_pos.size() !== 4) begin
      n_fail++; $display("FAIL ovf_npeaks: got %0d want 4", obs_pos.size());
    end
    for (int i = 0; i < 4 && i < obs_pos.size(); i++) begin
      n_cmp++;
      if (obs_pos[i] !== (2 * i + 1) * 2048 || obs_amp[i] !== 1000) begin
        n_fail++; $display("FAIL ovf_peak%0d: got pos=%0d amp=%0d want pos=%0d amp=1000", i,
                           obs_pos[i], obs_amp[i], (2 * i + 1) * 2048);
      end
    end
    n_cmp++;
    if (obs_ovf !== 1 || obs_count !== 4) begin
      n_fail++; $display("FAIL ovf_status: got ovf=%0d cnt=%0d want 1/4", obs_ovf, obs_count);
    end
  endtask

  task automatic test_backpressure();
    clear_mem();
    mem[7] = 16'd2000; mem[6] = 16'd300; mem[8] = 16'd300;
    mem[15] = 16'd900; mem[14] = 16'd100;
    model(0);
    run_scan(0, 10, 1'b0);
    n_cmp++;
    if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got unstable=%0d want 0", unstable); end
    n_cmp++;
    if (timed_out !== 0 || obs_pos.size() !== exp_pos.size() || obs_count !== exp_pos.size()) begin
      n_fail++; $display("FAIL bp_npeaks: got %0d cnt=%0d want %0d", obs_pos.size(), obs_count, exp_pos.size());
    end
    for (int i = 0; i < exp_pos.size() && i < obs_pos.size(); i++) begin
      n_cmp++;
      if (obs_pos[i] !== exp_pos[i] || obs_amp[i] !== exp_amp[i]) begin
        n_fail++; $display("FAIL bp_peak%0d: got %0d/%0d want %0d/%0d", i, obs_pos[i], obs_amp[i], exp_pos[i], exp_amp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int thr;
    for (int run = 0; run < 8; run++) begin
      for (int i = 0; i < BINS; i++) mem[i] = N'($urandom_range(0, 600));
      thr = (run == 7) ? 0 : int'($urandom_range(0, 2200));
      model(thr);
      run_scan(thr, int'($urandom_range(0, 2)), run[0]);
      n_cmp++;
      if (timed_out !== 0 || obs_pos.size() !== exp_pos.size()) begin
        n_fail++; $display("FAIL b2b%0d_npeaks: got %0d want %0d", run, obs_pos.size(), exp_pos.size());
      end
      for (int i = 0; i < exp_pos.size() && i < obs_pos.size(); i++) begin
        n_cmp++;
        if (obs_pos[i] !== exp_pos[i] || obs_amp[i] !== exp_amp[i]) begin
          n_fail++; $display("FAIL b2b%0d_peak%0d: got %0d/%0d want %0d/%0d", run, i,
                             obs_pos[i], obs_amp[i], exp_pos[i], exp_amp[i]);
        end
      end
      n_cmp++;
      if (obs_count !== exp_pos.size() || obs_ovf !== exp_ovf || unstable !== 0) begin
        n_fail++; $display("FAIL b2b%0d_status: got cnt=%0d ovf=%0d unstable=%0d want %0d/%0d/0",
                           run, obs_count, obs_ovf, unstable, exp_pos.size(), exp_ovf);
      end
    end
  endtask

  task automatic test_reset_mid_fold();
    int seen;
    seen = 0;
    clear_mem();
    mem[7] = 16'd2000; mem[6] = 16'd300; mem[8] = 16'd300;
    @(negedge clk); threshold = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || binAddr !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got busy=%b done=%b addr=%0d want 0/0/0", busy, done, binAddr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_done: got activity=%0d want 0", seen); end
    run_scan(0, 0, 1'b0);
    n_cmp++;
    if (timed_out !== 0 || obs_pos.size() != 1 || obs_pos[0] !== 14336 || obs_amp[0] !== 2000 || obs_count !== 1) begin
      n_fail++; $display("FAIL midrst_rerun: got n=%0d cnt=%0d want one peak 14336/2000 cnt=1",
                         obs_pos.size(), obs_count);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; peakReady = 1'b0; threshold = '0;
    clear_mem();
    test_reset();
    test_directed();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_fold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
